disp_value_conv: RTL
====================

DISP_VALUE_CONV -- requirements
Module: disp_value_conv

Interface
REQ-001 Parameter: DIV_LOG2, default 16, log2 of the led_clk period in clk cycles (legal range 2..24).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  in_value/in_dec present a new value to display.
REQ-005 in_ready  output  1  block can accept a value this cycle.
REQ-006 in_value  input  16  unsigned binary value to display.
REQ-007 in_dec  input  1  1 = decimal (BCD) display, 0 = hexadecimal display.
REQ-008 symbol  output  16  four display nibbles, [3:0] = rightmost digit; feeds the seven-segment driver.
REQ-009 ovf  output  1  decimal value exceeded 9999; only the low four digits are shown.
REQ-010 led_clk  output  1  digit-scan clock for the seven-segment driver; square wave with period 2^DIV_LOG2 clk cycles.

Function
REQ-011 The block SHALL implement states IDLE, CONV and DONE; in_ready SHALL be 1 only in IDLE with rst low.
REQ-012 Accept SHALL occur on an edge where in_valid && in_ready; at any other time, in_value, in_dec and in_valid SHALL be ignored.
REQ-013 Hex accept: at the accept edge, symbol <= in_value and ovf <= 0; state SHALL remain IDLE, so back-to-back hex accepts are legal every cycle.
REQ-014 Decimal accept at edge k: load a 36-bit shift register {20'b0, in_value} and a 5-bit iteration counter = 0; state <= CONV.
REQ-015 CONV, edges k+1..k+16: one double-dabble step per edge. Add 3 to each of the five BCD nibbles that is >= 5, then shift the register left 1; counter SHALL increment, and state <= DONE when it reaches 16.
REQ-016 DONE, edge k+17: symbol <= BCD digits 3..0, ovf <= (BCD digit 4 != 0), state <= IDLE; in_ready SHALL be high in the cycle after edge k+17.
REQ-017 symbol and ovf SHALL NOT change during CONV, so the display never shows partial results.
REQ-018 Boundaries: 9999 -> symbol 16'h9999, ovf 0; 10000 -> symbol 16'h0000, ovf 1; 0 -> 16'h0000, ovf 0; 65535 -> 16'h5535, ovf 1.
REQ-019 A free-running DIV_LOG2-bit counter SHALL increment every clk edge; led_clk SHALL equal its MSB, independent of conversion state.
REQ-020 led_clk SHALL be a registered output, glitch-free.

Reset
REQ-021 While rst is high at an edge, the block SHALL set: state IDLE, symbol 16'h0000, ovf 0, divider counter 0 (led_clk 0), shift register 0, iteration counter 0.
REQ-022 in_ready SHALL be 0 in any cycle in which rst is high.
REQ-023 Reset during CONV or DONE SHALL abort the conversion with no update to symbol or ovf other than the reset values; the first accept is possible in the cycle after rst falls.

Structure
REQ-024 Shared package disp_pkg SHALL hold: the state enumeration (IDLE/CONV/DONE), BCD_DIGITS = 5, CONV_ITERS = 16 and SYMBOL_W = 16.
REQ-025 One combinational sub-module bcd_digit_adj SHALL be used (4-bit in, 4-bit out: add 3 if >= 5), instantiated five times.
REQ-026 Target size: 120-400 lines RTL including the sub-module.

Verification
REQ-027 Hex: in_dec=0, in_value=16'hBEEF accepted at edge k -> symbol=16'hBEEF, ovf=0 after edge k; in_ready stays 1.
REQ-028 Decimal: in_dec=1, in_value=1234 accepted at edge k -> in_ready=0 for cycles k+1..k+17, symbol=16'h1234, ovf=0 after edge k+17, symbol unchanged before that.
REQ-029 Boundaries: decimal 9999, 10000 and 65535 -> 16'h9999/0, 16'h0000/1, 16'h5535/1 respectively.
REQ-030 in_valid held high with changing in_value during CONV -> ignored; result matches the value captured at the accept edge.
REQ-031 rst pulsed at edge k+8 of a decimal conversion -> symbol=0, ovf=0, in_ready=1 in the cycle after rst falls; a new hex accept then works.
REQ-032 DIV_LOG2=2 -> led_clk is 0,0,1,1 repeating after reset (period 4 clk), unaffected by concurrent conversions.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display value converter.
// Holds the FSM state encoding and the double-dabble register geometry.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 5;
  localparam int CONV_ITERS = 16;
  localparam int SYMBOL_W   = 16;
  localparam int ITER_W     = 5;
  // Five BCD nibbles sit above the 16-bit binary operand.
  localparam int SHIFT_W    = BCD_DIGITS * 4 + SYMBOL_W;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/disp_value_conv.sv
// Converts a 16-bit value to four display nibbles (hex pass-through or BCD via
// a 16-step double dabble) and generates the seven-segment scan clock.
module disp_value_conv
  import disp_pkg::*;
#(
  parameter int DIV_LOG2 = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SYMBOL_W-1:0] in_value,
  input  logic                in_dec,
  output logic [SYMBOL_W-1:0] symbol,
  output logic                ovf,
  output logic                led_clk,
  output state_t              fsm_state
);

  // Handshake: a value is taken on any rising edge where in_valid && in_ready.
  // in_ready is high only in IDLE and never while rst is high; in_valid may be
  // held or dropped freely, and inputs are ignored whenever no accept occurs.

  state_t                      state;
  state_t                      state_next;
  logic [SHIFT_W-1:0]          shift_reg;
  logic [ITER_W-1:0]           iter_cnt;
  logic [DIV_LOG2-1:0]         div_cnt;
  logic [BCD_DIGITS*4-1:0]     adj_bcd;
  logic [SHIFT_W-1:0]          adj_full;
  logic [SHIFT_W-1:0]          dabble_next;
  logic                        accept;

  assign accept = in_valid && in_ready;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (shift_reg[SYMBOL_W + 4*g +: 4]),
      .adjusted (adj_bcd[4*g +: 4])
    );
  end

  assign adj_full    = {adj_bcd, shift_reg[SYMBOL_W-1:0]};
  assign dabble_next = {adj_full[SHIFT_W-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && in_dec) state_next = CONV;
      CONV:    if (iter_cnt == ITER_W'(CONV_ITERS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    fsm_state = state;
  end

  // symbol/ovf only move on a hex accept or in DONE, never mid-conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      symbol    <= '0;
      ovf       <= 1'b0;
      shift_reg <= '0;
      iter_cnt  <= '0;
      div_cnt   <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_dec) begin
              shift_reg <= {{(BCD_DIGITS*4){1'b0}}, in_value};
              iter_cnt  <= '0;
            end else begin
              symbol <= in_value;
              ovf    <= 1'b0;
            end
          end
        end
        CONV: begin
          shift_reg <= dabble_next;
          iter_cnt  <= iter_cnt + 1'b1;
        end
        DONE: begin
          symbol <= shift_reg[SYMBOL_W +: SYMBOL_W];
          ovf    <= |shift_reg[SHIFT_W-1 -: 4];
        end
        default: ;
      endcase
    end
  end

  assign led_clk = div_cnt[DIV_LOG2-1];

endmodule
